conv_accumulator: RTL and testbench

Sums a fixed-length sequence of unsigned multiplier products into one convolution-window result. Sits directly downstream of the registered 8x8 multiplier stage in the convolution datapath. Accepts one 16-bit product per cycle under a valid/ready handshake and presents the finished window sum under a second valid/ready handshake to the activation/output stage.

---
 rtl/conv_accumulator.sv | 180 ++++++++++++++++++
 tb/tb_conv_accumulator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : conv_accumulator
// Description : Sums KERNEL_LEN unsigned multiplier products into one
//               convolution-window result. Products arrive one per cycle on
//               a valid/ready handshake. The finished sum is held on a second
//               valid/ready handshake until the downstream stage accepts it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_WIDTH   operand width of the upstream multiplier (default 8)
//   PROD_WIDTH  product width (default 2*NUM_WIDTH)
//   ACC_WIDTH   accumulator / result width, must be >= PROD_WIDTH (default 20)
//   KERNEL_LEN  products per window, legal range 1..255 (default 9)
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-low reset
//   flush       synchronous abort, discards any partial or held sum
//   prod_valid  prod_in carries a product
//   prod_in     unsigned product
//   prod_ready  block accepts a product this cycle (depends on state only)
//   acc_valid   acc_out holds a completed window sum
//   acc_out     window sum (driven from the accumulator in every state)
//   acc_ready   downstream accepts acc_out this cycle
//   acc_ovf     window sum exceeded ACC_WIDTH (saturating build only)
// Build option
//   ACC_SATURATE_EN  defined   : accumulator clamps to all-ones on overflow,
//                                acc_ovf is a sticky per-window flag
//                    undefined : accumulator wraps modulo 2^ACC_WIDTH,
//                                acc_ovf is held at 0
// ============================================================================

module conv_accumulator #(
    parameter int NUM_WIDTH  = 8,
    parameter int PROD_WIDTH = 2 * NUM_WIDTH,
    parameter int ACC_WIDTH  = 20,
    parameter int KERNEL_LEN = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  prod_valid,
    input  logic [PROD_WIDTH-1:0] prod_in,
    output logic                  prod_ready,
    output logic                  acc_valid,
    output logic [ACC_WIDTH-1:0]  acc_out,
    input  logic                  acc_ready,
    output logic                  acc_ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Count value at which the next accepted product completes the window.
    localparam logic [7:0] c_last_cnt = 8'(KERNEL_LEN - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_cnt;
    logic [7:0]             w_cnt_nxt;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [ACC_WIDTH-1:0]   w_acc_nxt;
    logic                   r_ovf;
    logic                   w_ovf_nxt;
    logic [ACC_WIDTH-1:0]   w_prod_ext;

    // Zero-extend the product; written this way so ACC_WIDTH == PROD_WIDTH
    // does not produce a zero-width replication.
    always_comb begin
        w_prod_ext                 = '0;
        w_prod_ext[PROD_WIDTH-1:0] = prod_in;
    end

`ifdef ACC_SATURATE_EN
    // One extra bit so the carry out of the accumulator MSB is visible.
    logic [ACC_WIDTH:0]     w_sum;
    assign w_sum = {1'b0, r_acc} + {1'b0, w_prod_ext};
`else
    // Carry is discarded, giving modulo 2^ACC_WIDTH wrap.
    logic [ACC_WIDTH-1:0]   w_sum;
    assign w_sum = r_acc + w_prod_ext;
`endif

    // Handshake outputs are decoded from the state register only, so there is
    // no combinational path from prod_valid or acc_ready to prod_ready.
    assign prod_ready = (r_state != S_HOLD);
    assign acc_valid  = (r_state == S_HOLD);
    assign acc_out    = r_acc;
    // In the wrapping build r_ovf is never set, so this output stays at 0.
    assign acc_ovf    = r_ovf;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;

        case (r_state)
            S_IDLE: begin
                // First product of a window replaces, rather than adds to,
                // whatever the previous window left in the accumulator.
                if (prod_valid) begin
                    w_acc_nxt   = w_prod_ext;
                    w_cnt_nxt   = 8'd1;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = (KERNEL_LEN == 1) ? S_HOLD : S_ACCUM;
                end
            end

            S_ACCUM: begin
                if (prod_valid) begin
                    w_cnt_nxt = r_cnt + 8'd1;
`ifdef ACC_SATURATE_EN
                    // Once clamped, stay clamped for the rest of the window.
                    if (r_ovf || w_sum[ACC_WIDTH]) begin
                        w_acc_nxt = '1;
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_acc_nxt = w_sum[ACC_WIDTH-1:0];
                    end
`else
                    w_acc_nxt = w_sum;
`endif
                    if (r_cnt == c_last_cnt) begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                // Sum (and overflow flag) stay put until the next window's
                // first product or a flush.
                if (acc_ready) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Flush overrides everything, including a product or result handshake
        // occurring in the same cycle.
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_acc_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_accumulator
// Description : Self-checking bench for conv_accumulator. Two instances share
//               one stimulus stream: a 20-bit accumulator (never overflows with
//               nine 16-bit products) and a 16-bit accumulator (overflows
//               readily). A window-level reference model predicts handshakes,
//               sums and the overflow flag for both instances.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_conv_accumulator;

    localparam int K = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        prod_valid;
    logic [15:0] prod_in;
    logic        acc_ready;

    logic        pr_a, av_a, ov_a;
    logic [19:0] acc_a;
    logic        pr_b, av_b, ov_b;
    logic [15:0] acc_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: whether a finished window is waiting, how many
    // products the current window has taken, and their exact integer total.
    bit     m_hold;
    int     m_cnt;
    longint m_total;

    always #5 clk = ~clk;

    conv_accumulator #(
        .NUM_WIDTH  (8),
        .PROD_WIDTH (16),
        .ACC_WIDTH  (20),
        .KERNEL_LEN (K)
    ) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .prod_valid (prod_valid),
        .prod_in    (prod_in),
        .prod_ready (pr_a),
        .acc_valid  (av_a),
        .acc_out    (acc_a),
        .acc_ready  (acc_ready),
        .acc_ovf    (ov_a)
    );

    conv_accumulator #(
        .NUM_WIDTH  (8),
        .PROD_WIDTH (16),
        .ACC_WIDTH  (16),
        .KERNEL_LEN (K)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .prod_valid (prod_valid),
        .prod_in    (prod_in),
        .prod_ready (pr_b),
        .acc_valid  (av_b),
        .acc_out    (acc_b),
        .acc_ready  (acc_ready),
        .acc_ovf    (ov_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected accumulator contents for a given width, from the exact total.
    function automatic logic [31:0] exp_acc(input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
`ifdef ACC_SATURATE_EN
        return (m_total > mx) ? 32'(mx) : 32'(m_total);
`else
        return 32'(m_total & mx);
`endif
    endfunction

    function automatic logic [31:0] exp_ovf(input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
`ifdef ACC_SATURATE_EN
        return (m_total > mx) ? 32'd1 : 32'd0;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_outputs(input string where);
        check({where, ".prod_ready_a"}, 32'(pr_a),  32'(!m_hold));
        check({where, ".prod_ready_b"}, 32'(pr_b),  32'(!m_hold));
        check({where, ".acc_valid_a"},  32'(av_a),  32'(m_hold));
        check({where, ".acc_valid_b"},  32'(av_b),  32'(m_hold));
        check({where, ".acc_out_a"},    32'(acc_a), exp_acc(20));
        check({where, ".acc_out_b"},    32'(acc_b), exp_acc(16));
        check({where, ".acc_ovf_a"},    32'(ov_a),  exp_ovf(20));
        check({where, ".acc_ovf_b"},    32'(ov_b),  exp_ovf(16));
    endtask

    task automatic reset_model();
        m_hold  = 1'b0;
        m_cnt   = 0;
        m_total = 0;
    endtask

    // One clock cycle: apply inputs, check the state-driven outputs, advance
    // across the rising edge, then update the model.
    task automatic step(input bit pv, input logic [15:0] pd, input bit ar, input bit fl);
        prod_valid = pv;
        prod_in    = pd;
        acc_ready  = ar;
        flush      = fl;
        check_outputs("step");
        @(posedge clk);
        #1;
        if (fl) begin
            reset_model();
        end else if (!m_hold && pv) begin
            if (m_cnt == 0) m_total = longint'(pd);
            else            m_total = m_total + longint'(pd);
            m_cnt++;
            if (m_cnt == K) m_hold = 1'b1;
        end else if (m_hold && ar) begin
            m_hold = 1'b0;
            m_cnt  = 0;
        end
    endtask

    // Asynchronous reset pulse in the middle of a cycle; outputs must return
    // to reset values before the next clock edge.
    task automatic pulse_reset(input string where);
        prod_valid = 1'b0;
        flush      = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        reset_model();
        check_outputs(where);
        check({where, ".ready_now"}, 32'(pr_a), 32'd1);
        check({where, ".acc_zero"},  32'(acc_a), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        prod_valid = 1'b0;
        prod_in    = '0;
        acc_ready  = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst.prod_ready", 32'(pr_a), 32'd1);
        check("rst.acc_valid",  32'(av_a), 32'd0);
        check("rst.acc_out",    32'(acc_a), 32'd0);
        check("rst.acc_ovf",    32'(ov_b), 32'd0);
        reset = 1'b1;

        // Nine maximal 8x8 products back to back, downstream always ready.
        for (int i = 0; i < K; i++) step(1'b1, 16'd65025, 1'b1, 1'b0);
        check("tp1.valid", 32'(av_a), 32'd1);
        check("tp1.sum_a", 32'(acc_a), 32'd585225);
`ifdef ACC_SATURATE_EN
        check("tp1.sum_b", 32'(acc_b), 32'd65535);
        check("tp1.ovf_b", 32'(ov_b),  32'd1);
`else
        check("tp1.sum_b", 32'(acc_b), 32'd60937);
        check("tp1.ovf_b", 32'(ov_b),  32'd0);
`endif
        check("tp1.ovf_a", 32'(ov_a), 32'd0);
        step(1'b1, 16'd5, 1'b1, 1'b0);
        check("tp1.ready_back", 32'(pr_a), 32'd1);

        // Products 1..9 with idle gaps, result held off by acc_ready=0.
        for (int i = 1; i <= K; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b0);
            if (i < K) begin
                check("tp2.not_yet", 32'(av_a), 32'd0);
                step(1'b0, 16'hFFFF, 1'b0, 1'b0);
            end
        end
        check("tp2.sum", 32'(acc_a), 32'd45);
        // Five stalled cycles with a product offered that must not be taken.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'd1000, 1'b0, 1'b0);
            check("tp3.stable_sum", 32'(acc_a), 32'd45);
            check("tp3.not_ready",  32'(pr_a),  32'd0);
        end
        step(1'b1, 16'd1000, 1'b1, 1'b0);
        check("tp3.idle_after", 32'(pr_a), 32'd1);

        // Flush a partial window (with a product offered in the flush cycle).
        for (int i = 0; i < 4; i++) step(1'b1, 16'd100, 1'b0, 1'b0);
        step(1'b1, 16'd100, 1'b0, 1'b1);
        check("tp4.flushed", 32'(acc_a), 32'd0);
        for (int i = 0; i < K; i++) step(1'b1, 16'd2, 1'b0, 1'b0);
        check("tp4.sum", 32'(acc_a), 32'd18);
        step(1'b0, 16'd0, 1'b1, 1'b0);

        // Reset while holding a result, then mid-window after five products.
        for (int i = 0; i < K; i++) step(1'b1, 16'd1, 1'b0, 1'b0);
        pulse_reset("rst_hold");
        for (int i = 0; i < 5; i++) step(1'b1, 16'd3, 1'b0, 1'b0);
        pulse_reset("rst_accum");
        for (int i = 0; i < K; i++) step(1'b1, 16'd1, 1'b0, 1'b0);
        check("tp6.sum", 32'(acc_a), 32'd9);
        step(1'b0, 16'd0, 1'b1, 1'b0);

        // Randomised traffic: gaps, backpressure, occasional flush, and a mix
        // of large products so the 16-bit instance overflows often.
        for (int i = 0; i < 600; i++) begin
            bit          pv, ar, fl;
            logic [15:0] pd;
            pv = ($urandom_range(0, 3) != 0);
            ar = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 1) == 1) pd = 16'($urandom_range(60000, 65535));
            else                           pd = 16'($urandom_range(0, 65535));
            step(pv, pd, ar, fl);
        end
        check_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
